// File: rtl/four_bank_mem_pkg.sv
// four_bank_mem_pkg: shared constants and helpers for the four-bank main memory.
// Bank interleaving is on word address bits, so consecutive words land in
// consecutive banks and a 4-word line burst never revisits a bank.
package four_bank_mem_pkg;

    localparam int NUM_BANKS = 4;
    localparam int ADDR_W    = 16;
    localparam int DATA_W    = 16;

    // Bank select field inside the byte address.
    localparam int BANK_LSB  = 1;
    localparam int BANK_MSB  = 2;
    localparam int BANK_W    = BANK_MSB - BANK_LSB + 1;

    // Row index starts just above the bank select field.
    localparam int ROW_LSB   = BANK_MSB + 1;

    // Width of a bank busy counter; it must hold BUSY_CYCLES-1.
    function automatic int cnt_width(input int busy_cycles);
        return $clog2(busy_cycles);
    endfunction

    // Bank targeted by a byte address.
    function automatic logic [BANK_W-1:0] bank_idx(input logic [ADDR_W-1:0] addr);
        return addr[BANK_MSB:BANK_LSB];
    endfunction

endpackage

// File: rtl/four_bank_mem_bank.sv
// mem_bank: one interleaved bank -- word array, write port, combinational
// read port and the busy counter that enforces the per-bank occupancy window.
// The array is deliberately not reset; only the counter is.
module mem_bank
    import four_bank_mem_pkg::*;
#(
    parameter int ROW_BITS    = 13,
    parameter int BUSY_CYCLES = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                acc_i,
    input  logic                wr_i,
    input  logic [ROW_BITS-1:0] row_i,
    input  logic [DATA_W-1:0]   wdata_i,
    output logic [DATA_W-1:0]   rdata_o,
    output logic                busy_o
);

    localparam int              CNT_W    = cnt_width(BUSY_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BUSY_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [DATA_W-1:0] mem_q [2**ROW_BITS];
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;

    // Busy counter next state: load on accept, otherwise count down to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (acc_i) begin
            cnt_d = CNT_LOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_ONE;
        end
    end

    // Busy counter register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Array write port: an accepted write lands at the accept edge.
    always_ff @(posedge clk_i) begin
        if (acc_i && wr_i) begin
            mem_q[row_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[row_i];
    assign busy_o  = (cnt_q != '0);

endmodule

// File: rtl/four_bank_mem.sv
// four_bank_mem: banked main-memory responder behind the cache memory port.
// One word request per cycle is steered to one of four interleaved banks;
// reads return exactly two cycles after acceptance.
// Build option: define UNALIGNED_ERR_EN to reject odd byte addresses via err;
// without it Addr[0] is ignored.
//
// Request handshake: a request is present while Rd|Wr is high. It is taken at
// the rising edge that ends a cycle where stall=0 and err=0. While stall=1 the
// requester must hold Addr/DataIn/Rd/Wr unchanged; err=1 means the request is
// dropped without any state change and must not be retried as-is.
module four_bank_mem
    import four_bank_mem_pkg::*;
#(
    parameter int ROW_BITS    = 13,
    parameter int BUSY_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 createdump,
    input  logic [ADDR_W-1:0]    Addr,
    input  logic [DATA_W-1:0]    DataIn,
    input  logic                 Rd,
    input  logic                 Wr,
    output logic [DATA_W-1:0]    DataOut,
    output logic                 data_valid,
    output logic                 stall,
    output logic [NUM_BANKS-1:0] busy,
    output logic                 err
);

    logic                 req;
    logic                 tgt_busy;
    logic                 accept;
    logic                 rd_accept;
    logic [BANK_W-1:0]    bank;
    logic [ROW_BITS-1:0]  row;
    logic [NUM_BANKS-1:0] bank_acc;
    logic [DATA_W-1:0]    bank_rdata [NUM_BANKS];

    // Read pipe: stage 1 captures the array word, stage 2 drives the outputs.
    logic                 s1_valid_q, s1_valid_d;
    logic [DATA_W-1:0]    s1_data_q,  s1_data_d;
    logic                 s2_valid_q, s2_valid_d;
    logic [DATA_W-1:0]    s2_data_q,  s2_data_d;

    // createdump only matters to simulation dump hooks; Addr[0] is unused
    // when odd addresses are silently aligned.
    logic unused_inputs;
    assign unused_inputs = &{1'b0, createdump, Addr[0]};

    assign bank = bank_idx(Addr);
    assign row  = Addr[ROW_LSB +: ROW_BITS];

    // Request decode: err wins over stall, and only a clean request to an idle bank is accepted.
    always_comb begin
        req = Rd | Wr;
        err = Rd & Wr;
`ifdef UNALIGNED_ERR_EN
        err = err | (req & Addr[0]);
`endif
        tgt_busy       = busy[bank];
        stall          = req & tgt_busy & ~err;
        accept         = req & ~tgt_busy & ~err;
        rd_accept      = accept & Rd;
        bank_acc       = '0;
        bank_acc[bank] = accept;
    end

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        mem_bank #(
            .ROW_BITS    (ROW_BITS),
            .BUSY_CYCLES (BUSY_CYCLES)
        ) u_bank (
            .clk_i   (clk),
            .rst_i   (rst),
            .acc_i   (bank_acc[g]),
            .wr_i    (Wr),
            .row_i   (row),
            .wdata_i (DataIn),
            .rdata_o (bank_rdata[g]),
            .busy_o  (busy[g])
        );
    end

    // Read pipe next state: stage 1 is empty unless a read is accepted this cycle.
    always_comb begin
        s1_valid_d = rd_accept;
        s1_data_d  = rd_accept ? bank_rdata[bank] : '0;
        s2_valid_d = s1_valid_q;
        s2_data_d  = s1_data_q;
    end

    // Read pipe registers; reset kills any in-flight read.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
        end
    end

    assign DataOut    = s2_valid_q ? s2_data_q : '0;
    assign data_valid = s2_valid_q;

endmodule

// File: tb/tb_four_bank_mem.sv
// tb_four_bank_mem: directed scenarios with literal expectations, followed by
// randomized traffic checked every cycle against a time-stamp based model of
// bank occupancy, a word-addressed memory image and a read-return queue.
module tb_four_bank_mem;

    localparam int BUSY = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        createdump;
    logic [15:0] Addr;
    logic [15:0] DataIn;
    logic        Rd;
    logic        Wr;
    logic [15:0] DataOut;
    logic        data_valid;
    logic        stall;
    logic [3:0]  busy;
    logic        err;

    always #5 clk = ~clk;

    four_bank_mem #(
        .ROW_BITS    (13),
        .BUSY_CYCLES (BUSY)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .createdump (createdump),
        .Addr       (Addr),
        .DataIn     (DataIn),
        .Rd         (Rd),
        .Wr         (Wr),
        .DataOut    (DataOut),
        .data_valid (data_valid),
        .stall      (stall),
        .busy       (busy),
        .err        (err)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    // Model state: cycle of last accept per bank, memory image, read returns.
    int          last_acc [4];
    logic [15:0] mem_m [int];
    logic [15:0] exp_q [$];
    int          due_q [$];
    bit          known_q [$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, got, exp);
        end
    endtask

    // Compare, then advance the model by the edge that ends this cycle.
    always @(negedge clk) begin
        bit          m_req;
        bit          m_err;
        bit          m_free;
        bit          exp_dv;
        int          b;
        logic [15:0] wa;
        logic [3:0]  exp_busy;

        m_req = Rd | Wr;
        m_err = Rd & Wr;
`ifdef UNALIGNED_ERR_EN
        if (m_req && Addr[0]) m_err = 1'b1;
`endif
        b      = int'(Addr[2:1]);
        wa     = Addr & 16'hFFFE;
        m_free = (cyc - last_acc[b]) >= BUSY;

        if (chk_en) begin
            for (int i = 0; i < 4; i++) begin
                exp_busy[i] = ((cyc - last_acc[i]) >= 1) && ((cyc - last_acc[i]) < BUSY);
            end
            while (due_q.size() > 0 && due_q[0] < cyc) begin
                void'(due_q.pop_front());
                void'(exp_q.pop_front());
                void'(known_q.pop_front());
            end
            exp_dv = (due_q.size() > 0) && (due_q[0] == cyc);
            check("err", 32'(err), 32'(m_err));
            check("stall", 32'(stall), 32'(m_req && !m_free && !m_err));
            check("busy", 32'(busy), 32'(exp_busy));
            check("data_valid", 32'(data_valid), 32'(exp_dv));
            if (exp_dv) begin
                if (known_q[0]) check("DataOut", 32'(DataOut), 32'(exp_q[0]));
                void'(due_q.pop_front());
                void'(exp_q.pop_front());
                void'(known_q.pop_front());
            end else begin
                check("DataOut_idle", 32'(DataOut), 32'h0);
            end
        end

        if (rst) begin
            chk_en = 1'b1;
            for (int i = 0; i < 4; i++) last_acc[i] = -100;
            exp_q.delete();
            due_q.delete();
            known_q.delete();
        end else if (chk_en && m_req && !m_err && m_free) begin
            last_acc[b] = cyc;
            if (Wr) begin
                mem_m[int'(wa)] = DataIn;
            end else begin
                due_q.push_back(cyc + 2);
                known_q.push_back(mem_m.exists(int'(wa)));
                exp_q.push_back(mem_m.exists(int'(wa)) ? mem_m[int'(wa)] : 16'h0);
            end
        end
        cyc++;
    end

    // Present a request for the current cycle and wait to its sampling point.
    task automatic drive(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d);
        Rd     = rd;
        Wr     = wr;
        Addr   = a;
        DataIn = d;
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 1'b0, 16'h0, 16'h0);
            tick();
        end
    endtask

    initial begin
        logic [15:0] a;
        logic        rdv;
        logic        wrv;
        int          r;

        for (int i = 0; i < 4; i++) last_acc[i] = -100;
        rst = 1'b1; createdump = 1'b0;
        Rd = 1'b0; Wr = 1'b0; Addr = 16'h0; DataIn = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state.
        drive(1'b0, 1'b0, 16'h0, 16'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_dv", 32'(data_valid), 32'h0);
        check("rst_dout", 32'(DataOut), 32'h0);
        check("rst_stall", 32'(stall), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        tick();

        // Write then read the same word after the busy window.
        drive(1'b0, 1'b1, 16'h0100, 16'hBEEF);
        check("t1_wr_stall", 32'(stall), 32'h0);
        tick();
        idle(3);
        drive(1'b1, 1'b0, 16'h0100, 16'h0);
        check("t1_rd_stall", 32'(stall), 32'h0);
        tick();
        drive(1'b0, 1'b0, 16'h0, 16'h0);
        check("t1_dv_early", 32'(data_valid), 32'h0);
        tick();
        drive(1'b0, 1'b0, 16'h0, 16'h0);
        check("t1_dv", 32'(data_valid), 32'h1);
        check("t1_data", 32'(DataOut), 32'hBEEF);
        tick();

        // Line-style write burst then read burst across all four banks.
        idle(4);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 16'h0200 + 16'(2 * i), 16'h1111 * 16'(i + 1));
            check("t2_wr_stall", 32'(stall), 32'h0);
            tick();
        end
        for (int i = 0; i < 7; i++) begin
            if (i < 4) drive(1'b1, 1'b0, 16'h0200 + 16'(2 * i), 16'h0);
            else       drive(1'b0, 1'b0, 16'h0, 16'h0);
            check("t2_rd_stall", 32'(stall), 32'h0);
            if (i >= 2 && i < 6) begin
                check("t2_dv", 32'(data_valid), 32'h1);
                check("t2_data", 32'(DataOut), 32'(16'h1111 * 16'(i - 1)));
            end else begin
                check("t2_dv_off", 32'(data_valid), 32'h0);
            end
            tick();
        end

        // Same-bank reuse: read held while bank 0 is busy.
        idle(4);
        drive(1'b0, 1'b1, 16'h0308, 16'h5A5A);
        tick();
        idle(4);
        drive(1'b0, 1'b1, 16'h0300, 16'h7777);
        check("t3_wr_stall", 32'(stall), 32'h0);
        tick();
        for (int k = 1; k <= 3; k++) begin
            drive(1'b1, 1'b0, 16'h0308, 16'h0);
            check("t3_stall", 32'(stall), 32'h1);
            check("t3_busy0", 32'(busy[0]), 32'h1);
            tick();
        end
        drive(1'b1, 1'b0, 16'h0308, 16'h0);
        check("t3_accept", 32'(stall), 32'h0);
        tick();
        idle(1);
        drive(1'b0, 1'b0, 16'h0, 16'h0);
        check("t3_dv", 32'(data_valid), 32'h1);
        check("t3_data", 32'(DataOut), 32'h5A5A);
        tick();

        // Rd and Wr together is dropped.
        idle(4);
        drive(1'b0, 1'b1, 16'h0400, 16'h1234);
        tick();
        idle(4);
        drive(1'b1, 1'b1, 16'h0400, 16'hDEAD);
        check("t4_err", 32'(err), 32'h1);
        check("t4_stall", 32'(stall), 32'h0);
        check("t4_busy", 32'(busy), 32'h0);
        tick();
        drive(1'b0, 1'b0, 16'h0, 16'h0);
        check("t4_busy_after", 32'(busy), 32'h0);
        tick();
        drive(1'b0, 1'b0, 16'h0, 16'h0);
        check("t4_no_dv", 32'(data_valid), 32'h0);
        tick();
        drive(1'b1, 1'b0, 16'h0400, 16'h0);
        check("t4_rd_stall", 32'(stall), 32'h0);
        tick();
        idle(1);
        drive(1'b0, 1'b0, 16'h0, 16'h0);
        check("t4_dv", 32'(data_valid), 32'h1);
        check("t4_data", 32'(DataOut), 32'h1234);
        tick();

        // Reset kills an in-flight read.
        idle(4);
        rst = 1'b1;
        drive(1'b1, 1'b0, 16'h0100, 16'h0);
        tick();
        rst = 1'b0;
        drive(1'b1, 1'b0, 16'h0100, 16'h0);
        check("t5_busy", 32'(busy), 32'h0);
        check("t5_stall", 32'(stall), 32'h0);
        check("t5_dv1", 32'(data_valid), 32'h0);
        tick();
        drive(1'b0, 1'b0, 16'h0, 16'h0);
        check("t5_dv2", 32'(data_valid), 32'h0);
        tick();
        drive(1'b0, 1'b0, 16'h0, 16'h0);
        check("t5_dv3", 32'(data_valid), 32'h1);
        check("t5_data", 32'(DataOut), 32'hBEEF);
        tick();

        // Odd address.
        idle(4);
        drive(1'b1, 1'b0, 16'h0101, 16'h0);
`ifdef UNALIGNED_ERR_EN
        check("t6_err", 32'(err), 32'h1);
`else
        check("t6_err", 32'(err), 32'h0);
`endif
        check("t6_stall", 32'(stall), 32'h0);
        tick();
        idle(1);
        drive(1'b0, 1'b0, 16'h0, 16'h0);
`ifdef UNALIGNED_ERR_EN
        check("t6_dv", 32'(data_valid), 32'h0);
`else
        check("t6_dv", 32'(data_valid), 32'h1);
        check("t6_data", 32'(DataOut), 32'hBEEF);
`endif
        tick();

        // Randomized traffic, checked by the per-cycle compare process.
        rdv = 1'b0; wrv = 1'b0; a = 16'h0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 99) >= 30 || n == 0) begin
                r = $urandom_range(0, 99);
                rdv = (r >= 20 && r < 60) || (r >= 95);
                wrv = (r >= 60);
                a = {10'd0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                     1'($urandom_range(0, 9) == 0)};
            end
            if ($urandom_range(0, 299) == 0) begin
                rst = 1'b1;
                wrv = 1'b0;
            end
            drive(rdv, wrv, a, 16'($urandom));
            tick();
            rst = 1'b0;
        end
        idle(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
